// File: rtl/cacheline_adapter.sv
// rtl/cacheline_adapter.sv - 256-bit cache line port to 4-beat 64-bit memory burst adapter.
// Owns beat sequencing, line packing/unpacking and line-address alignment.
module cacheline_adapter #(
  parameter int S_OFFSET = 5,
  parameter int S_LINE   = 256,
  parameter int S_BEAT   = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pmem_read,
  input  logic              pmem_write,
  input  logic [31:0]       pmem_address,
  input  logic [S_LINE-1:0] pmem_wdata,
  output logic              pmem_resp,
  output logic [S_LINE-1:0] pmem_rdata,
  output logic              burst_read,
  output logic              burst_write,
  output logic [31:0]       burst_address,
  output logic [S_BEAT-1:0] burst_wdata,
  input  logic [S_BEAT-1:0] burst_rdata,
  input  logic              burst_resp
);

  localparam int BEATS  = S_LINE / S_BEAT;
  localparam int CW     = $clog2(BEATS);
  localparam int BW     = $clog2(S_BEAT);
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [S_LINE-1:0] wline;
  logic [S_LINE-1:0] rline;

  // Gated by burst_write so the bus never shows stale line data outside a write burst.
  assign burst_wdata = burst_write ? wline[{cnt, {BW{1'b0}}} +: S_BEAT] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      wline         <= '0;
      rline         <= '0;
      pmem_resp     <= 1'b0;
      pmem_rdata    <= '0;
      burst_read    <= 1'b0;
      burst_write   <= 1'b0;
      burst_address <= '0;
    end else begin
      case (state)
        IDLE: begin
          pmem_resp <= 1'b0;
          cnt       <= '0;
          // Write wins so a dirty victim is written back before the allocate read.
          if (pmem_write) begin
            wline         <= pmem_wdata;
            burst_address <= {pmem_address[31:S_OFFSET], {S_OFFSET{1'b0}}};
            burst_write   <= 1'b1;
            state         <= WRITE;
          end else if (pmem_read) begin
            burst_address <= {pmem_address[31:S_OFFSET], {S_OFFSET{1'b0}}};
            burst_read    <= 1'b1;
            state         <= READ;
          end
        end
        READ: begin
          if (burst_resp) begin
            rline[{cnt, {BW{1'b0}}} +: S_BEAT] <= burst_rdata;
            cnt <= cnt + 1'b1;
            if (cnt == LAST) begin
              pmem_rdata <= {burst_rdata, rline[S_LINE-S_BEAT-1:0]};
              burst_read <= 1'b0;
              pmem_resp  <= 1'b1;
              state      <= DONE;
            end
          end
        end
        WRITE: begin
          if (burst_resp) begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST) begin
              burst_write <= 1'b0;
              pmem_resp   <= 1'b1;
              state       <= DONE;
            end
          end
        end
        DONE: begin
          pmem_resp <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cacheline_adapter.sv
// tb/tb_cacheline_adapter.sv - directed table-driven bench for cacheline_adapter.
module tb_cacheline_adapter;

  logic         clk;
  logic         rst;
  logic         pmem_read;
  logic         pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata;
  logic         pmem_resp;
  logic [255:0] pmem_rdata;
  logic         burst_read;
  logic         burst_write;
  logic [31:0]  burst_address;
  logic [63:0]  burst_wdata;
  logic [63:0]  burst_rdata;
  logic         burst_resp;

  int compared;
  int mismatched;

  cacheline_adapter dut (
    .clk(clk), .rst(rst),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata),
    .burst_read(burst_read), .burst_write(burst_write),
    .burst_address(burst_address), .burst_wdata(burst_wdata),
    .burst_rdata(burst_rdata), .burst_resp(burst_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         wr;
    logic [31:0]  addr;
    logic [255:0] wdata;
    logic [255:0] beats;     // {beat3, beat2, beat1, beat0}
    logic [15:0]  gaps;      // burst_resp per active cycle, bit 0 first
    logic [255:0] exp_rdata;
    logic [31:0]  exp_baddr;
    int           exp_lat;   // negedges from request to pmem_resp
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_txn(input vec_t v);
    int lat, gi, beat;
    logic got, br;
    @(negedge clk);
    pmem_write = v.wr; pmem_read = !v.wr;
    pmem_address = v.addr; pmem_wdata = v.wdata;
    burst_resp = 1'b0;
    lat = 0; gi = 0; beat = 0; got = 1'b0;
    while (!got && lat < 60) begin
      @(negedge clk);
      lat++;
      if (pmem_resp) begin
        got = 1'b1;
        burst_resp = 1'b0;
      end else if (burst_read || burst_write) begin
        pmem_address = ~v.addr;
        pmem_wdata = ~v.wdata;
        check("baddr", 256'(burst_address), 256'(v.exp_baddr));
        check("dir", 256'(burst_write), 256'(v.wr));
        check("exclusive", 256'(burst_read & burst_write), 256'(0));
        if (v.wr && beat < 4) check("wbeat", 256'(burst_wdata), 256'(v.wdata[64*beat +: 64]));
        br = (gi < 16) ? v.gaps[gi] : 1'b1;
        gi++;
        if (br && !v.wr && beat < 4) burst_rdata = v.beats[64*beat +: 64];
        if (br) beat++;
        burst_resp = br;
      end else begin
        burst_resp = 1'b0;
      end
    end
    check("latency", 256'(lat), 256'(v.exp_lat));
    check("rdata", pmem_rdata, v.exp_rdata);
    check("done_idle_bus", 256'({burst_read, burst_write}), 256'(0));
    pmem_read = 1'b0; pmem_write = 1'b0;
    @(negedge clk);
    check("single_pulse", 256'(pmem_resp), 256'(0));
  endtask

  int resp1, resp2, nresp, beat, cnt1;
  logic read_first, seen;

  initial begin
    compared = 0; mismatched = 0;
    rst = 1'b0; pmem_read = 1'b0; pmem_write = 1'b0;
    pmem_address = '0; pmem_wdata = '0; burst_rdata = '0; burst_resp = 1'b0;

    vecs[0] = '{1'b0, 32'h0000_1234, 256'h0,
                {64'h4444444444444444, 64'h3333333333333333, 64'h2222222222222222, 64'h1111111111111111},
                16'hFFFF,
                {64'h4444444444444444, 64'h3333333333333333, 64'h2222222222222222, 64'h1111111111111111},
                32'h0000_1220, 5};
    vecs[1] = '{1'b0, 32'hABCD_EF7F, 256'h0,
                {64'hF0F0F0F0F0F0F0F0, 64'h0F0F0F0F0F0F0F0F, 64'hFEDCBA9876543210, 64'h0123456789ABCDEF},
                16'hFFD9,
                {64'hF0F0F0F0F0F0F0F0, 64'h0F0F0F0F0F0F0F0F, 64'hFEDCBA9876543210, 64'h0123456789ABCDEF},
                32'hABCD_EF60, 8};
    vecs[2] = '{1'b1, 32'h8000_003F,
                {64'hDEADBEEF0BADF00D, 64'h3333333300000003, 64'h2222222200000002, 64'h1111111100000001},
                256'h0, 16'hFFF5,
                {64'hF0F0F0F0F0F0F0F0, 64'h0F0F0F0F0F0F0F0F, 64'hFEDCBA9876543210, 64'h0123456789ABCDEF},
                32'h8000_0020, 7};
    vecs[3] = '{1'b1, 32'h0000_0000,
                {64'h4444000000000004, 64'h3333000000000003, 64'h2222000000000002, 64'h1111000000000001},
                256'h0, 16'hFFFF,
                {64'hF0F0F0F0F0F0F0F0, 64'h0F0F0F0F0F0F0F0F, 64'hFEDCBA9876543210, 64'h0123456789ABCDEF},
                32'h0000_0000, 5};
    vecs[4] = '{1'b0, 32'h0000_0FE0, 256'h0,
                {64'hA5A5A5A5A5A5A5A5, 64'h5A5A5A5A5A5A5A5A, 64'hCAFEBABE00000002, 64'hCAFEBABE00000001},
                16'hFFFE,
                {64'hA5A5A5A5A5A5A5A5, 64'h5A5A5A5A5A5A5A5A, 64'hCAFEBABE00000002, 64'hCAFEBABE00000001},
                32'h0000_0FE0, 6};

    // Asynchronous reset mid-cycle
    #2 rst = 1'b1;
    #1;
    check("rst_outputs", 256'({pmem_resp, burst_read, burst_write, burst_address, burst_wdata}), 256'(0));
    check("rst_rdata", pmem_rdata, 256'(0));
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (10) begin @(negedge clk); if (pmem_resp !== 1'b0) seen = 1'b1; end
    check("idle_no_resp", 256'(seen), 256'(0));

    for (int i = 0; i < 5; i++) do_txn(vecs[i]);

    // Simultaneous write and read: write first, held read follows
    @(negedge clk);
    pmem_write = 1'b1; pmem_read = 1'b1;
    pmem_address = 32'h0000_4444; pmem_wdata = vecs[2].wdata;
    nresp = 0; beat = 0; resp1 = 0; resp2 = 0; read_first = 1'b0; cnt1 = 0;
    for (int c = 1; c <= 40 && nresp < 2; c++) begin
      @(negedge clk);
      if (pmem_resp) begin
        nresp++;
        if (nresp == 1) begin resp1 = c; pmem_write = 1'b0; end
        else begin resp2 = c; pmem_read = 1'b0; end
        beat = 0; burst_resp = 1'b0;
      end else if (burst_read || burst_write) begin
        if (burst_read && nresp == 0) read_first = 1'b1;
        if (burst_write && beat < 4) begin
          check("both_wbeat", 256'(burst_wdata), 256'(vecs[2].wdata[64*beat +: 64]));
          cnt1++;
        end
        if (burst_read && beat < 4) burst_rdata = vecs[0].beats[64*beat +: 64];
        burst_resp = 1'b1; beat++;
      end else begin
        burst_resp = 1'b0;
      end
    end
    check("both_nresp", 256'(nresp), 256'(2));
    check("both_write_first", 256'(read_first), 256'(0));
    check("both_wbeats", 256'(cnt1), 256'(4));
    check("both_resp1", 256'(resp1), 256'(5));
    check("both_resp2", 256'(resp2), 256'(11));
    check("both_rdata", pmem_rdata, vecs[0].beats);
    @(negedge clk);

    // Reset after two read beats
    pmem_read = 1'b1; pmem_address = 32'h0000_2040;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      burst_rdata = 64'hBAD0BAD0BAD0BAD0; burst_resp = 1'b1;
    end
    @(negedge clk);
    burst_resp = 1'b0;
    check("abort_active", 256'(burst_read), 256'(1));
    #2 rst = 1'b1;
    #1;
    check("abort_bus", 256'({burst_read, burst_write, pmem_resp, burst_address}), 256'(0));
    check("abort_rdata", pmem_rdata, 256'(0));
    pmem_read = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (10) begin @(negedge clk); if (pmem_resp !== 1'b0) seen = 1'b1; end
    check("abort_no_resp", 256'(seen), 256'(0));
    do_txn(vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
